// File: rtl/au_dec_pipe_if.sv
// Handshake bundle for au_dec_pipe: operand stream in, decrement result stream out.
// The borrow signal exists only when AU_DEC_BORROW_EN is defined.
interface au_dec_pipe_if #(
  parameter int WIDTH = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] a;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] z;
`ifdef AU_DEC_BORROW_EN
  logic             borrow;

  modport slave  (input  s_valid, a, m_ready, output s_ready, m_valid, z, borrow);
  modport master (output s_valid, a, m_ready, input  s_ready, m_valid, z, borrow);
`else
  modport slave  (input  s_valid, a, m_ready, output s_ready, m_valid, z);
  modport master (output s_valid, a, m_ready, input  s_ready, m_valid, z);
`endif
endinterface

// File: rtl/au_dec_pipe.sv
// Two-stage pipelined decrementer z = a - 1 built from a prefix AND of ~a.
// Optional macro AU_DEC_BORROW_EN adds a registered borrow flag (operand was zero).
module au_dec_pipe #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  au_dec_pipe_if.slave bus
);

  // bp[i] = &n[i:0]; ARCH 1 is Sklansky, ARCH 2 is Kogge-Stone, anything else ripples.
  function automatic logic [WIDTH-1:0] prefix_and(input logic [WIDTH-1:0] n);
    logic [WIDTH-1:0] x;
    x = n;
    case (ARCH)
      1: begin
        for (int l = 0; (32'd1 << l) < WIDTH; l++) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (((i >> l) & 32'd1) == 32'd1) x[i] = x[i] & x[((i >> l) << l) - 32'd1];
            else                             x[i] = x[i];
          end
        end
      end
      2: begin
        for (int l = 0; (32'd1 << l) < WIDTH; l++) begin
          for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i >= (32'd1 << l)) x[i] = x[i] & x[i - (32'd1 << l)];
            else                   x[i] = x[i];
          end
        end
      end
      default: begin
        for (int i = 1; i < WIDTH; i++) x[i] = x[i] & x[i-1];
      end
    endcase
    return x;
  endfunction

  logic             v1_q, v1_d, v2_q, v2_d;
  logic [WIDTH-1:0] a1_q, a1_d, mask1_q, mask1_d, z_q, z_d;
  logic [WIDTH-1:0] mask_s;
  logic             adv2_s, load_s;

`ifdef AU_DEC_BORROW_EN
  logic [WIDTH-1:0] bp_s;
  logic             brw1_q, brw1_d, brw_q, brw_d;

  assign bp_s   = prefix_and(~bus.a);
  assign mask_s = (bp_s << 32'd1) | WIDTH'(1'b1);
`else
  // Shifting drops bp[WIDTH-1]; WIDTH==1 degenerates to mask=1, z=~a.
  assign mask_s = (prefix_and(~bus.a) << 32'd1) | WIDTH'(1'b1);
`endif

  always_comb begin
    adv2_s  = ~v2_q | bus.m_ready;
    load_s  = bus.s_valid & (~v1_q | adv2_s);
    a1_d    = a1_q;
    mask1_d = mask1_q;
    z_d     = z_q;
`ifdef AU_DEC_BORROW_EN
    brw1_d  = brw1_q;
    brw_d   = brw_q;
`endif
    if (load_s) begin
      v1_d    = 1'b1;
      a1_d    = bus.a;
      mask1_d = mask_s;
`ifdef AU_DEC_BORROW_EN
      brw1_d  = bp_s[WIDTH-1];
`endif
    end else if (adv2_s) begin
      v1_d = 1'b0;
    end else begin
      v1_d = v1_q;
    end
    if (adv2_s) begin
      v2_d = v1_q;
      if (v1_q) begin
        z_d   = a1_q ^ mask1_q;
`ifdef AU_DEC_BORROW_EN
        brw_d = brw1_q;
`endif
      end else begin
        z_d = z_q;
      end
    end else begin
      v2_d = v2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      a1_q    <= '0;
      mask1_q <= '0;
      z_q     <= '0;
`ifdef AU_DEC_BORROW_EN
      brw1_q  <= 1'b0;
      brw_q   <= 1'b0;
`endif
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      a1_q    <= a1_d;
      mask1_q <= mask1_d;
      z_q     <= z_d;
`ifdef AU_DEC_BORROW_EN
      brw1_q  <= brw1_d;
      brw_q   <= brw_d;
`endif
    end
  end

  assign bus.s_ready = ~v1_q | ~v2_q | bus.m_ready;
  assign bus.m_valid = v2_q;
  assign bus.z       = z_q;
`ifdef AU_DEC_BORROW_EN
  assign bus.borrow  = brw_q;
`endif

endmodule
